// File: rtl/l2sw_tx_arbiter.sv
// Frame-granular round-robin merge of two FWFT 72-bit frame FIFOs onto one tx read port.
// Also keeps saturating per-source frame counters and a sticky oversize flag.
module l2sw_tx_arbiter #(
    parameter int          CntWidth = 16,
    parameter logic [11:0] MaxWords = 12'd1200
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [71:0]         in0_dout,
    input  logic                in0_empty,
    output logic                in0_rd_en,
    input  logic [71:0]         in1_dout,
    input  logic                in1_empty,
    output logic                in1_rd_en,
    output logic [71:0]         dout,
    output logic                empty,
    input  logic                rd_en,
    output logic [1:0]          grant,
    output logic [CntWidth-1:0] frm_cnt0,
    output logic [CntWidth-1:0] frm_cnt1,
    output logic                oversize
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS0 = 2'd1,
        PASS1 = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        rr;
    logic [11:0] word_cnt;
    logic        pop;
    logic        last_pop;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
            grant <= 2'b00;
        end else begin
            state <= next_state;
            grant <= {next_state == PASS1, next_state == PASS0};
        end
    end

    // In IDLE the rr pointer only breaks ties; a lone requester always wins.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!in0_empty && (in1_empty || !rr))
                    next_state = PASS0;
                else if (!in1_empty)
                    next_state = PASS1;
            end
            PASS0, PASS1: begin
                if (last_pop)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        dout      = 72'h0;
        empty     = 1'b1;
        in0_rd_en = 1'b0;
        in1_rd_en = 1'b0;
        case (state)
            PASS0: begin
                dout      = in0_dout;
                empty     = in0_empty;
                in0_rd_en = rd_en & ~in0_empty;
            end
            PASS1: begin
                dout      = in1_dout;
                empty     = in1_empty;
                in1_rd_en = rd_en & ~in1_empty;
            end
            default: begin
                dout      = 72'h0;
                empty     = 1'b1;
            end
        endcase
    end

    assign pop      = in0_rd_en | in1_rd_en;
    assign last_pop = pop && (dout[71:64] != 8'hff);

    // Word counter saturates so a runaway frame cannot wrap and clear the oversize test.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rr       <= 1'b0;
            word_cnt <= 12'd0;
            frm_cnt0 <= '0;
            frm_cnt1 <= '0;
            oversize <= 1'b0;
        end else begin
            if (pop && (({1'b0, word_cnt} + 13'd1) >= {1'b0, MaxWords}))
                oversize <= 1'b1;
            if (last_pop) begin
                word_cnt <= 12'd0;
                rr       <= (state == PASS0);
                if (state == PASS0 && frm_cnt0 != '1)
                    frm_cnt0 <= frm_cnt0 + CntWidth'(1);
                if (state == PASS1 && frm_cnt1 != '1)
                    frm_cnt1 <= frm_cnt1 + CntWidth'(1);
            end else if (pop && word_cnt != 12'hfff) begin
                word_cnt <= word_cnt + 12'd1;
            end
        end
    end

endmodule

// File: tb/tb_l2sw_tx_arbiter.sv
// Bench for l2sw_tx_arbiter: queue-backed FWFT sources, frame-level round-robin model.
// Counter width is reduced so saturation is reachable in a short run.
module tb_l2sw_tx_arbiter;

    localparam int          CW = 6;
    localparam logic [11:0] MW = 12'd1200;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b0;
    logic [71:0]   in0_dout = 72'h0;
    logic          in0_empty = 1'b1;
    logic          in0_rd_en;
    logic [71:0]   in1_dout = 72'h0;
    logic          in1_empty = 1'b1;
    logic          in1_rd_en;
    logic [71:0]   dout;
    logic          empty;
    logic          rd_en = 1'b0;
    logic [1:0]    grant;
    logic [CW-1:0] frm_cnt0;
    logic [CW-1:0] frm_cnt1;
    logic          oversize;

    int asserts = 0;
    int fails   = 0;
    int inv_err = 0;

    logic [71:0] q0[$];
    logic [71:0] q1[$];
    logic [71:0] held0[$];
    logic [71:0] fr[$];
    logic [71:0] m_w0[$];
    logic [71:0] m_w1[$];
    int          m_n0[$];
    int          m_n1[$];
    logic [73:0] exp_q[$];
    logic [73:0] obs_q[$];
    int          m_rr;
    int          m_cnt0;
    int          m_cnt1;
    logic        m_over;

    l2sw_tx_arbiter #(.CntWidth(CW), .MaxWords(MW)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .in0_dout  (in0_dout),
        .in0_empty (in0_empty),
        .in0_rd_en (in0_rd_en),
        .in1_dout  (in1_dout),
        .in1_empty (in1_empty),
        .in1_rd_en (in1_rd_en),
        .dout      (dout),
        .empty     (empty),
        .rd_en     (rd_en),
        .grant     (grant),
        .frm_cnt0  (frm_cnt0),
        .frm_cnt1  (frm_cnt1),
        .oversize  (oversize)
    );

    always #5 sys_clk = ~sys_clk;

    // FWFT source FIFOs: pop on the edge, head word appears after the edge.
    always @(posedge sys_clk) begin
        if (in0_rd_en && q0.size() > 0) void'(q0.pop_front());
        if (in1_rd_en && q1.size() > 0) void'(q1.pop_front());
        in0_empty <= (q0.size() == 0);
        in0_dout  <= (q0.size() > 0) ? q0[0] : 72'h0;
        in1_empty <= (q1.size() == 0);
        in1_dout  <= (q1.size() > 0) ? q1[0] : 72'h0;
    end

    // Records every word that the coming edge will pop, and flags pop/grant inconsistencies.
    always @(negedge sys_clk) begin
        if (rd_en && !empty && !sys_rst) obs_q.push_back({grant, dout});
        if ((in0_rd_en || in1_rd_en) !== (rd_en && !empty)) inv_err++;
        if (in0_rd_en && grant !== 2'b01) inv_err++;
        if (in1_rd_en && grant !== 2'b10) inv_err++;
    end

    task automatic check_output(input string tag, input logic [79:0] got, input logic [79:0] want);
        asserts++;
        assert (got === want) else begin
            fails++;
            $error("[TB] FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic gen_frame(input int n, input logic [7:0] last_mask);
        fr.delete();
        for (int i = 0; i < n - 1; i++) fr.push_back({8'hff, $urandom, $urandom});
        fr.push_back({last_mask, $urandom, $urandom});
    endtask

    function automatic logic [7:0] rand_last_mask();
        return 8'($urandom_range(0, 254));
    endfunction

    task automatic push_fifo(input int src);
        foreach (fr[i]) begin
            if (src == 0) q0.push_back(fr[i]);
            else          q1.push_back(fr[i]);
        end
    endtask

    task automatic model_add(input int src);
        foreach (fr[i]) begin
            if (src == 0) m_w0.push_back(fr[i]);
            else          m_w1.push_back(fr[i]);
        end
        if (src == 0) m_n0.push_back(fr.size());
        else          m_n1.push_back(fr.size());
    endtask

    task automatic apply_stimulus(input int src);
        push_fifo(src);
        model_add(src);
    endtask

    // Frame-order model: whole frames, ties broken by the pointer, pointer moves to the other source.
    task automatic model_build();
        while (m_n0.size() > 0 || m_n1.size() > 0) begin
            int s;
            int n;
            if (m_n0.size() > 0 && m_n1.size() > 0) s = m_rr;
            else                                    s = (m_n0.size() > 0) ? 0 : 1;
            n = (s == 0) ? m_n0.pop_front() : m_n1.pop_front();
            for (int i = 0; i < n; i++) begin
                if (s == 0) exp_q.push_back({2'b01, m_w0.pop_front()});
                else        exp_q.push_back({2'b10, m_w1.pop_front()});
            end
            if (s == 0) m_cnt0 = (m_cnt0 < CNT_MAX) ? m_cnt0 + 1 : CNT_MAX;
            else        m_cnt1 = (m_cnt1 < CNT_MAX) ? m_cnt1 + 1 : CNT_MAX;
            if (n >= int'(MW)) m_over = 1'b1;
            m_rr = 1 - s;
        end
    endtask

    task automatic apply_reset(input int cycles);
        rd_en   = 1'b0;
        sys_rst = 1'b1;
        repeat (cycles) step();
        sys_rst = 1'b0;
        m_rr    = 0;
        m_cnt0  = 0;
        m_cnt1  = 0;
        m_over  = 1'b0;
        exp_q.delete();
        obs_q.delete();
        m_w0.delete();
        m_w1.delete();
        m_n0.delete();
        m_n1.delete();
    endtask

    task automatic drain(input string tag, input bit rand_rd, input int budget);
        int cyc = 0;
        model_build();
        while (obs_q.size() < exp_q.size() && cyc < budget) begin
            rd_en = rand_rd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            cyc++;
        end
        rd_en = 1'b0;
        step();
        step();
        check_output({tag, " words"}, 80'(obs_q.size()), 80'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check_output($sformatf("%s word %0d", tag, i), 80'(obs_q[i]), 80'(exp_q[i]));
        check_output({tag, " grant idle"}, 80'(grant), 80'(2'b00));
        check_output({tag, " empty idle"}, 80'(empty), 80'(1'b1));
        check_output({tag, " frm_cnt0"}, 80'(frm_cnt0), 80'(m_cnt0));
        check_output({tag, " frm_cnt1"}, 80'(frm_cnt1), 80'(m_cnt1));
        check_output({tag, " oversize"}, 80'(oversize), 80'(m_over));
        check_output({tag, " pop rules"}, 80'(inv_err), 80'(0));
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int cyc;

        // Reset state.
        apply_reset(2);
        check_output("rst empty", 80'(empty), 80'(1'b1));
        check_output("rst grant", 80'(grant), 80'(2'b00));
        check_output("rst frm_cnt0", 80'(frm_cnt0), 80'(0));
        check_output("rst frm_cnt1", 80'(frm_cnt1), 80'(0));
        check_output("rst oversize", 80'(oversize), 80'(1'b0));
        check_output("rst in0_rd_en", 80'(in0_rd_en), 80'(1'b0));
        check_output("rst in1_rd_en", 80'(in1_rd_en), 80'(1'b0));
        check_output("rst dout", 80'(dout), 80'(72'h0));

        // Single source, grant one cycle after the FIFO shows data.
        gen_frame(3, 8'h0f);
        apply_stimulus(0);
        rd_en = 1'b1;
        step();
        check_output("single idle grant", 80'(grant), 80'(2'b00));
        check_output("single idle empty", 80'(empty), 80'(1'b1));
        step();
        check_output("single grant", 80'(grant), 80'(2'b01));
        drain("single", 1'b0, 50);

        // Contention from a fresh pointer: 0,1,0,1.
        apply_reset(1);
        for (int f = 0; f < 2; f++) begin
            gen_frame($urandom_range(1, 6), rand_last_mask());
            apply_stimulus(0);
            gen_frame($urandom_range(1, 6), rand_last_mask());
            apply_stimulus(1);
        end
        drain("contend", 1'b0, 200);

        // Source 0 stalls mid-frame while source 1 waits.
        gen_frame(3, 8'h3f);
        model_add(0);
        q0.push_back(fr[0]);
        held0.delete();
        for (int i = 1; i < fr.size(); i++) held0.push_back(fr[i]);
        gen_frame(2, 8'h07);
        apply_stimulus(1);
        rd_en = 1'b1;
        cyc = 0;
        while (obs_q.size() < 1 && cyc < 20) begin
            step();
            cyc++;
        end
        check_output("stall first word", 80'(obs_q.size()), 80'(1));
        for (int c = 0; c < 5; c++) begin
            check_output($sformatf("stall grant %0d", c), 80'(grant), 80'(2'b01));
            check_output($sformatf("stall empty %0d", c), 80'(empty), 80'(1'b1));
            check_output($sformatf("stall in1_rd_en %0d", c), 80'(in1_rd_en), 80'(1'b0));
            step();
        end
        foreach (held0[i]) q0.push_back(held0[i]);
        drain("stall", 1'b0, 100);

        // Random frames on both sources under random backpressure.
        for (int f = 0; f < 5; f++) begin
            gen_frame($urandom_range(1, 8), rand_last_mask());
            apply_stimulus(0);
            gen_frame($urandom_range(1, 8), rand_last_mask());
            apply_stimulus(1);
        end
        drain("backpressure", 1'b1, 2000);

        // 16-byte frame closed by a mask-00 word.
        gen_frame(3, 8'h00);
        apply_stimulus(1);
        drain("mask00", 1'b0, 50);

        // Oversize: one word short, then exactly the limit, then sticky.
        gen_frame(int'(MW) - 1, 8'h01);
        apply_stimulus(0);
        drain("below limit", 1'b0, 3000);
        gen_frame(int'(MW), 8'h01);
        apply_stimulus(0);
        drain("at limit", 1'b0, 3000);
        gen_frame(2, 8'h03);
        apply_stimulus(1);
        drain("oversize sticky", 1'b0, 50);

        // Counter saturation.
        apply_reset(1);
        for (int f = 0; f < CNT_MAX; f++) begin
            gen_frame(1, rand_last_mask());
            apply_stimulus(0);
        end
        drain("cnt at max", 1'b0, 1000);
        for (int f = 0; f < 7; f++) begin
            gen_frame(1, rand_last_mask());
            apply_stimulus(0);
        end
        drain("cnt saturated", 1'b0, 200);

        // Reset after word 2 of a 5-word frame; the rest becomes a new frame.
        apply_reset(1);
        gen_frame(5, 8'h1f);
        push_fifo(0);
        rd_en = 1'b1;
        cyc = 0;
        while (obs_q.size() < 2 && cyc < 20) begin
            step();
            cyc++;
        end
        check_output("midrst words", 80'(obs_q.size()), 80'(2));
        if (obs_q.size() >= 2) begin
            check_output("midrst word 0", 80'(obs_q[0]), 80'({2'b01, fr[0]}));
            check_output("midrst word 1", 80'(obs_q[1]), 80'({2'b01, fr[1]}));
        end
        apply_reset(1);
        check_output("midrst grant", 80'(grant), 80'(2'b00));
        check_output("midrst empty", 80'(empty), 80'(1'b1));
        check_output("midrst in0_rd_en", 80'(in0_rd_en), 80'(1'b0));
        fr.delete(0);
        fr.delete(0);
        model_add(0);
        drain("midrst rest", 1'b0, 50);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/l2sw_tx_arbiter.md
Name: l2sw_tx_arbiter

Overview:
- Merges the 72-bit frame streams from two rx PHY-queue FIFOs onto one tx path.
- The output is a FIFO-style read port that feeds the fifo72toxgmii instance of one tx MAC.
- Arbitration is frame-granular and round-robin, so frames from the two sources never interleave.
- Carries per-source forwarded-frame counters for LED/debug use.

Parameters:
- CntWidth, 16, width of the per-source frame counters (saturating).
- MaxWords, 12'd1200, word-count limit per frame; any frame reaching it is flagged as oversize.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge
- sys_rst  in  1  synchronous, active-high reset
- in0_dout  in  72  source 0 FIFO data, first-word-fall-through (valid while !in0_empty)
- in0_empty  in  1  source 0 FIFO empty
- in0_rd_en  out  1  source 0 pop
- in1_dout  in  72  source 1 FIFO data, first-word-fall-through
- in1_empty  in  1  source 1 FIFO empty
- in1_rd_en  out  1  source 1 pop
- dout  out  72  merged data to the tx converter
- empty  out  1  merged stream empty
- rd_en  in  1  pop from the tx converter
- grant  out  2  one-hot current owner; 2'b00 when idle
- frm_cnt0  out  CntWidth  frames forwarded from source 0
- frm_cnt1  out  CntWidth  frames forwarded from source 1
- oversize  out  1  sticky: some frame reached MaxWords

Behaviour:
- Word format
  - [71:64] is the byte-valid mask; [63:0] is data, byte 0 in [7:0].
  - A word with mask != 8'hff is the last word of a frame.
  - Frames whose length is a multiple of 8 bytes end with a mask-8'h00 word.
- Reset (sys_rst=1 on a clock edge):
  - state=IDLE, rr pointer=0 (source 0 preferred next).
  - grant=0, frm_cnt0=frm_cnt1=0, oversize=0, word counter=0.
  - Combinational outputs follow: empty=1, in0_rd_en=in1_rd_en=0, dout=72'h0.
  - Reset mid-frame abandons the frame; no words are generated.
- States: IDLE, PASS0, PASS1.
- IDLE
  - Only !in0_empty: go to PASS0 next cycle.
  - Only !in1_empty: go to PASS1.
  - Both non-empty: go to the source the rr pointer names.
  - Neither: stay in IDLE.
  - empty=1 throughout IDLE, so there is one idle cycle between frames.
- PASSn (zero-latency combinational passthrough)
  - dout=inN_dout, empty=inN_empty, inN_rd_en=rd_en & !inN_empty.
  - The other source's rd_en is 0.
  - If the source runs empty mid-frame, empty=1 and the grant is held. There is no timeout.
  - On a pop of a word with mask != 8'hff:
    - next state=IDLE;
    - rr pointer = other source;
    - frm_cntN increments, saturating at all-ones.
- Word counter
  - Increments on each pop in PASSn and clears when the frame ends.
  - When it reaches MaxWords, oversize is set and stays set until reset. Passthrough continues.
- grant
  - Registered one-hot, equal to the state: PASS0→01, PASS1→10.
- rd_en asserted while empty=1 is ignored: no pop, no state change.

Test Plan:
- Reset: sys_rst high 2 cycles → empty=1, grant=00, frm_cnt0=frm_cnt1=0, oversize=0, in*_rd_en=0.
- Single source: load in0 with a 3-word frame (masks ff, ff, 0f), rd_en held 1 → grant=01 one cycle after !in0_empty; dout matches the 3 words in order; then IDLE; frm_cnt0=1, in1_rd_en never 1.
- Contention: both FIFOs hold 2 frames each, rd_en=1 → output frame order is 0,1,0,1 with no interleaving; frm_cnt0=frm_cnt1=2.
- Stall and backpressure:
  - in0 goes empty after word 1 for 5 cycles while in1 is non-empty → grant stays 01, empty=1, in1_rd_en=0; the frame resumes intact.
  - rd_en toggled 1/0 → exactly one pop per rd_en=1 cycle.
- Boundaries:
  - A 16-byte frame ending with a mask-00 word → the 00 word is forwarded and ends the frame.
  - A frame of MaxWords words → oversize=1 and remains set.
  - frm_cnt preset near saturation by driving 65 536 frames (CntWidth=16) → holds at 16'hffff.
- Reset mid-frame: assert sys_rst after word 2 of a 5-word frame → IDLE next cycle; the remaining words are later treated as a new frame.
